rsa_modexp: RTL and testbench
=============================

# rsa_modexp

Modular-exponentiation engine that consumes the keys produced by the key generator: it computes `result = msg^exp mod n` using the public key (`e`, `n`) to encrypt or the private key (`d`, `n`) to decrypt. It is right-to-left binary square-and-multiply built on one shared serial modular multiplier. It is the timing-leak target for side-channel experiments, so its cycle count is specified exactly. A compile-time switch selects a constant-time build.

## Interface
- `W`, default 16: operand width; matches the key generator's `n`/`d` width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request. Sampled only in IDLE.
- `msg` input W: base operand. Sampled on the `start` edge.
- `exp` input W: exponent (`e` or `d`, zero-extended). Sampled on the `start` edge.
- `n` input W: modulus. Sampled on the `start` edge.
- `result` output W: `msg^exp mod n`. Held from `finish` until the next accepted `start`.
- `finish` output 1: one-cycle pulse; `result`/`err` are valid in that cycle.
- `busy` output 1: high from the cycle after an accepted `start` through the `finish` cycle.
- `err` output 1: operand error flag, valid with `finish`.

## Operation
- Reset values: `result`=0, `finish`=0, `busy`=0, `err`=0, state IDLE. Reset mid-operation aborts immediately; no `finish` follows.
- States: IDLE, CHECK, MUL, SQR, DONE.
- IDLE: on `start`:
  - latch `n` and `exp`;
  - `base`=`msg`, `acc`=1, bit counter `k`=0;
  - go to CHECK.
  - `start` in any other state is ignored.
- Operand error: if `n`<2 or `msg`>=`n` at start, go to DONE with `result`=0 and `err`=1.
- CHECK (1 cycle):
  - terminate → DONE;
  - else if `exp[0]`=1 → MUL;
  - else → SQR.
- MUL: `acc` = `acc*base mod n` via the multiplier, then → SQR.
- SQR: `base` = `base*base mod n`, then `exp` >>= 1, `k`++, → CHECK.
- DONE: `finish`=1, `result`=`acc` (or 0 on error), → IDLE.
- `exp`=0 gives `result`=1 (for `n`>=2).
- Multiplier `mod_mul` (sub-module): interleaved MSB-first, `a*b mod n` for `a`,`b` < `n`.
  - Per bit: `t = 2*t + (b_i ? a : 0)`, then subtract `n` up to twice.
  - Internal width W+2; no overflow for `n` < 2^W.
  - Handshake: `go` pulse in, `done` pulse out.

## Timing
- `M` = `mod_mul` latency = W+1 cycles: W iterations plus 1 result cycle. For W=16, M=17.
- Cycle 0 is the `start` edge; the first CHECK is cycle 1.
- Per processed exponent bit: 1 + (bit ? M : 0) + M cycles.
- Default build:
  - terminates at the CHECK that sees remaining `exp`==0;
  - latency = 2 + Σ over bits 0..msb(exp) of (1 + M + bit·M);
  - `exp`=0 → `finish` at cycle 2.
- Error path: `finish` at cycle 2.
- `busy` rises at cycle 1 and falls after the `finish` cycle.
- Back-to-back operation: `start` in the cycle after `finish` is accepted.

## Configuration
- `RSA_CONST_TIME_EN` defined:
  - CHECK terminates only when `k`==W.
  - MUL always executes; when `exp[0]`=0 its product is written to a dummy register and `acc` is unchanged.
  - Latency is fixed at 2 + W·(1+2M), i.e. 562 for W=16, independent of `exp` and `msg`.
  - The error path also waits the full latency.
- Undefined: the data-dependent latency above, which is the intended side channel.

## Structure
- Package `rsa_pkg` holds:
  - the state enum (IDLE, CHECK, MUL, SQR, DONE);
  - the constant `RSA_W`=16;
  - function `mm_latency(W)`=W+1, shared by RTL and bench.
- One sub-module, `mod_mul`, instantiated once and time-shared by MUL and SQR.

## Test plan
- Encrypt: `msg`=65, `exp`=3, `n`=3127 → `result`=2576, `err`=0; default build `finish` at cycle 72.
- Decrypt: `msg`=2576, `exp`=2011, `n`=3127 → `result`=65; default latency matches the formula; CT build latency is exactly 562.
- Edge operands:
  - `exp`=0, `msg`=5, `n`=3127 → `result`=1, `finish` at cycle 2 (default build).
  - `msg`=0, `exp`=7 → `result`=0.
- Errors: `n`=1 → `err`=1, `result`=0. Likewise `msg`=3127 with `n`=3127 → `err`=1, `result`=0.
- Control:
  - `rst_n` low at cycle 30 of a decrypt → all outputs 0 at once, no `finish`.
  - A new `start` after reset completes correctly.
  - `start` while `busy` is ignored.
- Timing leak: under the default build, `exp`=0x8000 and `exp`=0xFFFF produce different latencies; under `RSA_CONST_TIME_EN` they are identical, with the random-check comparison against a reference model passing.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared state encoding, default operand width and multiplier latency for the RSA modexp engine.
package rsa_pkg;

  localparam int RSA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    SQR,
    DONE
  } rsa_state_t;

  // Serial multiplier latency: W shift/add iterations plus one result cycle.
  function automatic int mm_latency(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/rsa_modexp_mod_mul.sv
// Interleaved MSB-first modular multiplier: o_p = i_a*i_b mod i_n for i_a, i_b < i_n.
// Latency mm_latency(W): operands taken with i_go, o_done pulses W+1 cycles later; i_go is only legal while !o_busy.
module mod_mul
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_go,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_p,
  output logic         o_busy,
  output logic         o_done
);

  localparam int ITER = mm_latency(W) - 1;
  localparam int CW   = $clog2(ITER + 1);

  logic [W+1:0]  r_t;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_n;
  logic [CW-1:0] r_cnt;
  logic          r_run;

  logic [W-1:0]  w_a;
  logic          w_bit;
  logic [W+1:0]  w_t_in;
  logic [W+1:0]  w_n_ext;
  logic [W+1:0]  w_sum;
  logic [W+1:0]  w_s1;
  logic [W+1:0]  w_t_next;

  // The first iteration runs in the go cycle straight from the input operands,
  // so the product is ready after exactly W edges.
  always_comb begin
    w_a      = i_go ? i_a : r_a;
    w_bit    = i_go ? i_b[W-1] : r_b[W-1];
    w_t_in   = i_go ? '0 : r_t;
    w_n_ext  = {2'b00, (i_go ? i_n : r_n)};
    w_sum    = {w_t_in[W:0], 1'b0} + (w_bit ? {2'b00, w_a} : '0);
    w_s1     = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
    w_t_next = (w_s1 >= w_n_ext) ? (w_s1 - w_n_ext) : w_s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_n   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_go) begin
      r_t   <= w_t_next;
      r_a   <= i_a;
      r_b   <= {i_b[W-2:0], 1'b0};
      r_n   <= i_n;
      r_cnt <= CW'(1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == CW'(ITER)) begin
        r_run <= 1'b0;
      end else begin
        r_t   <= w_t_next;
        r_b   <= {r_b[W-2:0], 1'b0};
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_p    = r_t[W-1:0];
  assign o_busy = r_run;
  assign o_done = r_run && (r_cnt == CW'(ITER));

endmodule

// File: rtl/rsa_modexp.sv
// Right-to-left square-and-multiply: result = msg^exp mod n over one shared mod_mul.
// RSA_CONST_TIME_EN: fixed 2+W*(1+2M) cycle latency; otherwise latency depends on the exponent bits.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] msg,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] n,
  output logic [W-1:0] result,
  output logic         finish,
  output logic         busy,
  output logic         err
);

  localparam int KW = $clog2(W + 1);

  rsa_state_t    r_state;
  rsa_state_t    w_next;

  logic [W-1:0]  r_n;
  logic [W-1:0]  r_exp;
  logic [W-1:0]  r_base;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_result;
  logic [KW-1:0] r_k;
  logic          r_err;
  logic          r_err_out;

  logic          w_op_err;
  logic          w_term;
  logic          w_mm_go;
  logic          w_mm_busy;
  logic          w_mm_done;
  logic [W-1:0]  w_mm_a;
  logic [W-1:0]  w_mm_p;

`ifdef RSA_CONST_TIME_EN
  logic [W-1:0]  r_dummy;
`endif

  assign w_op_err = (n < W'(2)) || (msg >= n);

`ifdef RSA_CONST_TIME_EN
  assign w_term = (r_k == KW'(W));
`else
  assign w_term = r_err || (r_exp == '0) || (r_k == KW'(W));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = CHECK;
      CHECK: begin
        if (w_term) w_next = DONE;
`ifdef RSA_CONST_TIME_EN
        else        w_next = MUL;
`else
        else if (r_exp[0]) w_next = MUL;
        else               w_next = SQR;
`endif
      end
      MUL:   if (w_mm_done) w_next = SQR;
      SQR:   if (w_mm_done) w_next = CHECK;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    finish  = (r_state == DONE);
    w_mm_go = ((r_state == MUL) || (r_state == SQR)) && !w_mm_busy;
    w_mm_a  = (r_state == MUL) ? r_acc : r_base;
  end

  mod_mul #(
    .W(W)
  ) u_mod_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_go   (w_mm_go),
    .i_a    (w_mm_a),
    .i_b    (r_base),
    .i_n    (r_n),
    .o_p    (w_mm_p),
    .o_busy (w_mm_busy),
    .o_done (w_mm_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_exp     <= '0;
      r_base    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_k       <= '0;
      r_err     <= 1'b0;
      r_err_out <= 1'b0;
`ifdef RSA_CONST_TIME_EN
      r_dummy   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_n    <= n;
          r_exp  <= exp;
          // Zeroed base keeps the multiplier inside its operand range on the error path.
          r_base <= w_op_err ? '0 : msg;
          r_acc  <= W'(1);
          r_k    <= '0;
          r_err  <= w_op_err;
        end
        CHECK: if (w_term) begin
          r_result  <= r_err ? '0 : r_acc;
          r_err_out <= r_err;
        end
        MUL: if (w_mm_done) begin
`ifdef RSA_CONST_TIME_EN
          if (r_exp[0]) r_acc   <= w_mm_p;
          else          r_dummy <= w_mm_p;
`else
          r_acc <= w_mm_p;
`endif
        end
        SQR: if (w_mm_done) begin
          r_base <= w_mm_p;
          r_exp  <= {1'b0, r_exp[W-1:1]};
          r_k    <= r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign err    = r_err_out;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed + random bench for rsa_modexp with a queue scoreboard of result/err/latency.
module tb_rsa_modexp;
  import rsa_pkg::*;

  localparam int W = RSA_W;
  localparam int M = mm_latency(W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] msg = '0;
  logic [W-1:0] exp = '0;
  logic [W-1:0] n = '0;
  logic [W-1:0] result;
  logic         finish;
  logic         busy;
  logic         err;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rsa_modexp #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .msg    (msg),
    .exp    (exp),
    .n      (n),
    .result (result),
    .finish (finish),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] m);
    longint unsigned r, x, mm;
    logic [W-1:0] ee;
    if (m < 2 || b >= m) return '0;
    mm = longint'(m);
    r  = 1;
    x  = longint'(b);
    ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * x) % mm;
      x  = (x * x) % mm;
      ee = ee >> 1;
    end
    return W'(r);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] e, input logic bad);
`ifdef RSA_CONST_TIME_EN
    return 2 + W * (1 + 2 * M);
`else
    int l;
    logic [W-1:0] x;
    l = 2;
    x = e;
    if (bad) return 2;
    while (x != 0) begin
      l = l + 1 + M + (x[0] ? M : 0);
      x = x >> 1;
    end
    return l;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic issue(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                       input logic [W-1:0] nn, input bit track);
    exp_t x;
    logic bad;
    bad   = (nn < 2) || (m >= nn);
    x.res = ref_modexp(m, e, nn);
    x.err = bad;
    x.lat = ref_latency(e, bad);
    x.tag = tag;
    if (track) sb.push_back(x);
    @(negedge clk);
    msg   = m;
    exp   = e;
    n     = nn;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after the start edge (cycle 1); poke_at>0 injects a start while busy.
  task automatic wait_finish(input int poke_at, output int lat_obs);
    exp_t x;
    int   c;
    bit   seen;
    x    = sb.pop_front();
    c    = 1;
    seen = 1'b0;
    chk({x.tag, "_busy_c1"}, busy, 1);
    while (c < 2000) begin
      if (finish) begin
        seen = 1'b1;
        break;
      end
      if (c == poke_at) begin
        msg   = 7;
        exp   = 1;
        n     = 11;
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      c++;
    end
    lat_obs = c;
    chk({x.tag, "_finish_seen"}, seen, 1);
    if (seen) begin
      chk({x.tag, "_result"}, result, x.res);
      chk({x.tag, "_err"}, err, x.err);
      chk({x.tag, "_latency"}, c, x.lat);
      chk({x.tag, "_busy_at_finish"}, busy, 1);
    end
    @(posedge clk);
    #1;
    chk({x.tag, "_finish_pulse"}, finish, 0);
    chk({x.tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int lat;
    int lat_a;
    int lat_b;
    int fin_cnt;
    logic [W-1:0] rn;
    logic [W-1:0] rm;
    logic [W-1:0] re;

    // Reset state
    #12;
    chk("rst_result", result, 0);
    chk("rst_finish", finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("encrypt", 16'd65, 16'd3, 16'd3127, 1'b1);
    wait_finish(0, lat);
`ifndef RSA_CONST_TIME_EN
    chk("encrypt_cycle72", lat, 72);
`endif

    issue("decrypt_poke", 16'd2576, 16'd2011, 16'd3127, 1'b1);
    wait_finish(5, lat);

    issue("exp_zero", 16'd5, 16'd0, 16'd3127, 1'b1);
    wait_finish(0, lat);

    issue("msg_zero", 16'd0, 16'd7, 16'd3127, 1'b1);
    wait_finish(0, lat);

    issue("err_n1", 16'd0, 16'd3, 16'd1, 1'b1);
    wait_finish(0, lat);

    issue("err_msg_ge_n", 16'd3127, 16'd3, 16'd3127, 1'b1);
    wait_finish(0, lat);

    // Abort a decrypt with reset at cycle 30
    issue("abort", 16'd2576, 16'd2011, 16'd3127, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_finish", finish, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    fin_cnt = 0;
    repeat (400) begin
      @(posedge clk);
      #1 if (finish) fin_cnt++;
    end
    chk("abort_no_finish", fin_cnt, 0);

    issue("after_reset", 16'd2576, 16'd2011, 16'd3127, 1'b1);
    wait_finish(0, lat);

    // Timing leak comparison
    issue("leak_8000", 16'd123, 16'h8000, 16'd3127, 1'b1);
    wait_finish(0, lat_a);
    issue("leak_ffff", 16'd123, 16'hFFFF, 16'd3127, 1'b1);
    wait_finish(0, lat_b);
`ifdef RSA_CONST_TIME_EN
    chk("leak_equal", lat_a, lat_b);
`else
    chk("leak_differs", (lat_a != lat_b), 1);
`endif

    for (int i = 0; i < 8; i++) begin
      rn = W'($urandom_range(65535, 2));
      rm = W'($urandom_range(int'(rn) - 1, 0));
      re = W'($urandom);
      issue($sformatf("rand%0d", i), rm, re, rn, 1'b1);
      wait_finish(0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
